int_request_ctrl: RTL and testbench
===================================

# int_request_ctrl

Interrupt request controller on the device side of the CP0 interrupt interface. It synchronises raw device interrupt lines, edge-detects them and latches them as pending. Each pending channel is masked and routed to one of the two CP0 external request lines, `sw_int[1:0]`. The controller holds each request until CP0 acknowledges it, then tracks the accepted source as in-service until software writes end-of-interrupt (EOI) over a small memory-mapped register port.

## Interface
- `N_IRQ`, default 8: number of device channels, legal range 1..32.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `dev_irq`  in  N_IRQ  raw device requests, asynchronous, rising-edge significant.
- `int_ack`  in  1  single-cycle pulse; CP0 has accepted a request on line `ack_line`.
- `ack_line`  in  1  which `sw_int` line was accepted (1 = cause 2, 0 = cause 1).
- `bus_we`  in  1  register write strobe.
- `bus_addr`  in  2  register select.
- `bus_wdata`  in  32  write data.
- `bus_rdata`  out  32  read data; combinational from `bus_addr`.
- `sw_int`  out  2  request lines to CP0 `SW_INT`.

## Operation
- Per channel path: 2-flop synchroniser, then rising-edge detect (`sync2 & ~prev`). A detected edge sets `pending[i]`.
- Registers:
  - addr 0, PENDING: read returns `pending`; write-1-to-clear.
  - addr 1, MASK: read/write; 1 = enabled.
  - addr 2, ROUTE: read/write; 1 = channel goes to `sw_int[1]`, 0 = `sw_int[0]`.
  - addr 3, ISR: read returns `{14'b0, in_service[1:0], 3'b0, active_id1[4:0], 3'b0, active_id0[4:0]}`. A write with bit k = 1 is EOI for line k and clears `in_service[k]`.
- Eligibility: `elig_k = pending & MASK & (ROUTE == k)`, evaluated per channel.
- Request output: `sw_int[k] = |elig_k & ~in_service[k]`. It is combinational from flops only, so it is glitch-free.
- Acknowledge: on `int_ack` with `ack_line = k`:
  - select the lowest-index channel in `elig_k`;
  - clear its pending bit;
  - set `in_service[k]` and load `active_idk` with the channel index.
- An acknowledge with `elig_k` empty or `in_service[k]` already set is ignored.
- Per-line state is IDLE (`in_service = 0`), which moves to SERVICE on an accepted ack. SERVICE returns to IDLE on EOI for that line.
- Masked pending bits stay pending. Unmasking them raises `sw_int` in the same cycle as the MASK write takes effect.
- Simultaneous events:
  - Edge detect and W1C clear on the same channel: set wins.
  - Edge detect on the channel being acked: the pending bit stays set.
  - EOI and accepted ack on the same line: ack wins, so the line stays in service with the new id.
  - MASK/ROUTE write in the same cycle as an ack: the ack selects using the old values.
- Reset clears pending, MASK, ROUTE, in_service, active ids, synchroniser and prev flops. Therefore `sw_int = 0` and `bus_rdata` reads 0 at every address.
- A device line held high through reset registers exactly one pending event after reset release.
- `rst` asserted during service abandons the service; there is no acknowledge replay.

## Timing
- Latency from `dev_irq` rising to `sw_int` high is 3 clock edges: sync1, sync2, pending.
- `sw_int[k]` falls immediately after the clock edge that samples `int_ack`. A second eligible channel keeps the line low until EOI.
- EOI write: `sw_int[k]` may reassert right after the write edge.
- Register writes take effect at the sampling edge. Reads are same-cycle combinational.
- Minimum device pulse width is 1 clock period plus synchroniser setup. Shorter pulses may be lost.

## Structure
- Package `int_ctrl_pkg` holds:
  - register address constants `REG_PENDING`, `REG_MASK`, `REG_ROUTE`, `REG_ISR`;
  - ISR field offsets;
  - id width constant (5).
- Sub-module `irq_sync_edge`: 2-flop synchroniser plus rising-edge detector, vectored over N_IRQ channels, synchronous reset to 0.
- Top level contains pending/mask/route registers, two priority encoders (one per line), the in-service state and the bus decode.

## Test plan
- Edge to request: MASK = 0x01, ROUTE = 0, pulse `dev_irq[0]` → `sw_int = 2'b01` exactly 3 edges later; PENDING reads 0x01.
- Priority on ack: MASK = 0xFF, ROUTE = 0x0C, edges on channels 3 and 2 together → `sw_int[1] = 1`. Ack with `ack_line = 1` → ISR reads `active_id1 = 2` and `in_service[1] = 1`; PENDING = 0x08; `sw_int[1] = 0` until writing ISR = 0x2, then `sw_int[1]` reasserts for channel 3.
- Mask hold: MASK = 0, edge on channel 5 → `sw_int = 0` and PENDING = 0x20. Write MASK = 0x20 → `sw_int[0] = 1` in the next cycle.
- Collisions:
  - W1C of channel 1 in the same cycle as a new channel-1 edge → PENDING bit 1 stays 1.
  - EOI on line 0 in the same cycle as an accepted ack on line 0 → `in_service[0]` stays 1 with the new id.
- Spurious ack: `int_ack` with an empty eligible set → ISR unchanged and equal to 0.
- Reset mid-service: line 0 in service with pending 0x06, assert `rst` for 1 cycle → all registers 0 and `sw_int = 0`. A device held high through reset gives PENDING set 3 edges after release.

Source files
------------

// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the interrupt request controller.
// Holds register addresses, ISR field offsets, the channel id width, the per-line
// service state type and a lowest-set-bit index helper.
package int_ctrl_pkg;

  localparam int unsigned ID_W = 5;

  localparam logic [1:0] REG_PENDING = 2'd0;
  localparam logic [1:0] REG_MASK    = 2'd1;
  localparam logic [1:0] REG_ROUTE   = 2'd2;
  localparam logic [1:0] REG_ISR     = 2'd3;

  // ISR read layout: {14'b0, in_service[1:0], 3'b0, id1, 3'b0, id0}
  localparam int unsigned ISR_ID0_LSB   = 0;
  localparam int unsigned ISR_ID1_LSB   = 8;
  localparam int unsigned ISR_INSVC_LSB = 16;

  typedef enum logic {LnIdle, LnService} line_state_e;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [ID_W-1:0] lowest_idx(input logic [31:0] v);
    logic [ID_W-1:0] idx;
    idx = '0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) idx = i[ID_W-1:0];
    end
    return idx;
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Two-flop synchroniser plus rising-edge detector, one per device channel.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (clears all flops)
//   dev_irq   : raw asynchronous device request lines
//   irq_edge  : one-cycle pulse per synchronised rising edge
module irq_sync_edge #(
  parameter int unsigned N_IRQ = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] dev_irq,
  output logic [N_IRQ-1:0] irq_edge
);

  logic [N_IRQ-1:0] sync1_q, sync2_q, prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= dev_irq;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign irq_edge = sync2_q & ~prev_q;

endmodule

// File: rtl/int_request_ctrl.sv
// Device-side interrupt request controller for the CP0 interrupt interface.
// Latches synchronised device edges as pending, masks and routes them to two
// request lines, holds a line until CP0 acknowledges, then keeps the accepted
// channel in service until software writes EOI.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   dev_irq[N_IRQ]      : raw device requests (rising edge significant)
//   int_ack, ack_line   : CP0 accept pulse and the sw_int line it accepted
//   bus_we/addr/wdata   : register write port (PENDING W1C, MASK, ROUTE, ISR EOI)
//   bus_rdata           : combinational read data for bus_addr
//   sw_int[1:0]         : request lines to CP0
module int_request_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int unsigned N_IRQ = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] dev_irq,
  input  logic             int_ack,
  input  logic             ack_line,
  input  logic             bus_we,
  input  logic [1:0]       bus_addr,
  input  logic [31:0]      bus_wdata,
  output logic [31:0]      bus_rdata,
  output logic [1:0]       sw_int
);

  logic [N_IRQ-1:0] irq_edge;
  logic [N_IRQ-1:0] pending_q, pending_d;
  logic [N_IRQ-1:0] mask_q, mask_d;
  logic [N_IRQ-1:0] route_q, route_d;
  line_state_e      line_q [2];
  line_state_e      line_d [2];
  logic [ID_W-1:0]  active_id_q [2];
  logic [ID_W-1:0]  active_id_d [2];

  logic [N_IRQ-1:0] elig [2];
  logic [ID_W-1:0]  sel [2];
  logic [1:0]       in_service;
  logic [N_IRQ-1:0] ack_elig, ack_onehot;
  logic             ack_ok;
  logic [1:0]       ack_hit, eoi;
  logic             wr_pending, wr_mask, wr_route, wr_isr;
  logic             unused_wdata;

  irq_sync_edge #(
    .N_IRQ(N_IRQ)
  ) u_sync_edge (
    .clk     (clk),
    .rst     (rst),
    .dev_irq (dev_irq),
    .irq_edge(irq_edge)
  );

  assign wr_pending = bus_we && (bus_addr == REG_PENDING);
  assign wr_mask    = bus_we && (bus_addr == REG_MASK);
  assign wr_route   = bus_we && (bus_addr == REG_ROUTE);
  assign wr_isr     = bus_we && (bus_addr == REG_ISR);
  assign eoi        = wr_isr ? bus_wdata[1:0] : 2'b00;
  assign unused_wdata = ^bus_wdata;

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      in_service[k] = (line_q[k] == LnService);
    end
  end

  assign elig[0] = pending_q & mask_q & ~route_q;
  assign elig[1] = pending_q & mask_q & route_q;
  assign sel[0]  = lowest_idx(32'(elig[0]));
  assign sel[1]  = lowest_idx(32'(elig[1]));

  // Requests depend only on flops, so sw_int cannot glitch on bus activity.
  assign sw_int[0] = (|elig[0]) & ~in_service[0];
  assign sw_int[1] = (|elig[1]) & ~in_service[1];

  // Ack selection always uses pre-edge pending/mask/route.
  assign ack_elig   = ack_line ? elig[1] : elig[0];
  assign ack_onehot = ack_elig & ~(ack_elig - 1'b1);
  assign ack_ok     = int_ack && (|ack_elig) && !in_service[ack_line];
  assign ack_hit    = {ack_ok & ack_line, ack_ok & ~ack_line};

  always_comb begin
    pending_d = pending_q;
    if (wr_pending) pending_d = pending_d & ~bus_wdata[N_IRQ-1:0];
    if (ack_ok)     pending_d = pending_d & ~ack_onehot;
    // A fresh edge overrides both the W1C and the ack clear.
    pending_d = pending_d | irq_edge;

    mask_d  = wr_mask  ? bus_wdata[N_IRQ-1:0] : mask_q;
    route_d = wr_route ? bus_wdata[N_IRQ-1:0] : route_q;
  end

  // Per-line service FSM. Ack is only accepted from idle, so an EOI in the same
  // cycle is overridden by the new service naturally.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      line_d[k]      = line_q[k];
      active_id_d[k] = active_id_q[k];
      unique case (line_q[k])
        LnIdle: begin
          if (ack_hit[k]) begin
            line_d[k]      = LnService;
            active_id_d[k] = sel[k];
          end
        end
        LnService: begin
          if (eoi[k]) line_d[k] = LnIdle;
        end
        default: line_d[k] = LnIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      mask_q    <= '0;
      route_q   <= '0;
      for (int k = 0; k < 2; k++) begin
        line_q[k]      <= LnIdle;
        active_id_q[k] <= '0;
      end
    end else begin
      pending_q <= pending_d;
      mask_q    <= mask_d;
      route_q   <= route_d;
      for (int k = 0; k < 2; k++) begin
        line_q[k]      <= line_d[k];
        active_id_q[k] <= active_id_d[k];
      end
    end
  end

  always_comb begin
    bus_rdata = '0;
    unique case (bus_addr)
      REG_PENDING: bus_rdata[N_IRQ-1:0] = pending_q;
      REG_MASK:    bus_rdata[N_IRQ-1:0] = mask_q;
      REG_ROUTE:   bus_rdata[N_IRQ-1:0] = route_q;
      REG_ISR: begin
        bus_rdata[ISR_ID0_LSB +: ID_W] = active_id_q[0];
        bus_rdata[ISR_ID1_LSB +: ID_W] = active_id_q[1];
        bus_rdata[ISR_INSVC_LSB +: 2]  = in_service;
      end
      default: bus_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_int_request_ctrl.sv
// Self-checking bench for int_request_ctrl: directed scenarios with literal
// expectations, then randomized traffic compared every cycle to a reference model.
module tb_int_request_ctrl;

  localparam int unsigned N = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  dev_irq;
  logic          int_ack;
  logic          ack_line;
  logic          bus_we;
  logic [1:0]    bus_addr;
  logic [31:0]   bus_wdata;
  logic [31:0]   bus_rdata;
  logic [1:0]    sw_int;

  always #10 clk = ~clk;

  int_request_ctrl #(
    .N_IRQ(N)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .dev_irq  (dev_irq),
    .int_ack  (int_ack),
    .ack_line (ack_line),
    .bus_we   (bus_we),
    .bus_addr (bus_addr),
    .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata),
    .sw_int   (sw_int)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference model state
  bit           m_valid = 1'b0;
  logic [N-1:0] m_pend, m_mask, m_route;
  logic [N-1:0] s_a, s_b, s_c;  // dev_irq sampled 1, 2 and 3 edges ago
  bit           m_isv [2];
  int           m_id  [2];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] m_elig(input int k);
    logic [N-1:0] e;
    for (int i = 0; i < N; i++) e[i] = m_pend[i] & m_mask[i] & (m_route[i] == (k == 1));
    return e;
  endfunction

  function automatic logic [1:0] m_sw();
    logic [1:0] s;
    for (int k = 0; k < 2; k++) s[k] = (m_elig(k) != '0) && !m_isv[k];
    return s;
  endfunction

  function automatic logic [31:0] m_rdata(input logic [1:0] a);
    logic [31:0] r;
    r = '0;
    case (a)
      2'd0: r[N-1:0] = m_pend;
      2'd1: r[N-1:0] = m_mask;
      2'd2: r[N-1:0] = m_route;
      default: begin
        r[17]   = m_isv[1];
        r[16]   = m_isv[0];
        r[12:8] = m_id[1][4:0];
        r[4:0]  = m_id[0][4:0];
      end
    endcase
    return r;
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic m_step();
    logic [N-1:0] edges, e;
    int k, sel;
    bit acc;
    if (rst) begin
      m_pend = '0; m_mask = '0; m_route = '0;
      s_a = '0; s_b = '0; s_c = '0;
      m_isv[0] = 0; m_isv[1] = 0; m_id[0] = 0; m_id[1] = 0;
      m_valid = 1'b1;
      return;
    end
    edges = s_b & ~s_c;
    k = ack_line ? 1 : 0;
    e = m_elig(k);
    sel = -1;
    for (int i = N - 1; i >= 0; i--) if (e[i]) sel = i;
    acc = int_ack && (sel >= 0) && !m_isv[k];
    if (bus_we && bus_addr == 2'd0) m_pend = m_pend & ~bus_wdata[N-1:0];
    if (acc) m_pend[sel] = 1'b0;
    m_pend = m_pend | edges;
    if (bus_we && bus_addr == 2'd3) begin
      if (bus_wdata[0]) m_isv[0] = 0;
      if (bus_wdata[1]) m_isv[1] = 0;
    end
    if (acc) begin
      m_isv[k] = 1;
      m_id[k]  = sel;
    end
    if (bus_we && bus_addr == 2'd1) m_mask  = bus_wdata[N-1:0];
    if (bus_we && bus_addr == 2'd2) m_route = bus_wdata[N-1:0];
    s_c = s_b; s_b = s_a; s_a = dev_irq;
  endtask

  // Called just after a falling edge with inputs already driven: compare, then
  // let one rising edge pass and update the model.
  task automatic tick();
    #1;
    if (m_valid) begin
      check("sw_int", {30'd0, sw_int}, {30'd0, m_sw()});
      check("bus_rdata", bus_rdata, m_rdata(bus_addr));
    end
    @(posedge clk);
    m_step();
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus_we = 1'b1; bus_addr = a; bus_wdata = d;
    tick();
    bus_we = 1'b0; bus_wdata = '0;
  endtask

  task automatic rd_check(input string name, input logic [1:0] a, input logic [31:0] exp);
    bus_addr = a;
    #1;
    check(name, bus_rdata, exp);
  endtask

  task automatic sw_check(input string name, input logic [1:0] exp);
    #1;
    check(name, {30'd0, sw_int}, {30'd0, exp});
  endtask

  task automatic ack(input logic line);
    int_ack = 1'b1; ack_line = line;
    tick();
    int_ack = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; dev_irq = '0; int_ack = 1'b0; ack_line = 1'b0;
    bus_we = 1'b0; bus_addr = 2'd0; bus_wdata = '0;
    tick();
    rst = 1'b0;
    for (int a = 0; a < 4; a++) rd_check("reset_rdata", 2'(a), 32'h0);
    sw_check("reset_sw_int", 2'b00);

    // Edge to request latency
    wr(2'd1, 32'h01);
    dev_irq[0] = 1'b1;
    ticks(2);
    sw_check("edge_after_2", 2'b00);
    tick();
    sw_check("edge_after_3", 2'b01);
    rd_check("edge_pending", 2'd0, 32'h01);
    dev_irq = '0;

    // Priority on ack and EOI reassert
    do_reset();
    wr(2'd1, 32'hFF);
    wr(2'd2, 32'h0C);
    dev_irq = 8'h0C;
    ticks(3);
    sw_check("prio_req", 2'b10);
    ack(1'b1);
    dev_irq = '0;
    rd_check("prio_isr", 2'd3, 32'h0002_0200);
    rd_check("prio_pending", 2'd0, 32'h08);
    sw_check("prio_held_low", 2'b00);
    ticks(2);
    sw_check("prio_still_low", 2'b00);
    wr(2'd3, 32'h2);
    sw_check("prio_eoi_reassert", 2'b10);
    rd_check("prio_isr_after_eoi", 2'd3, 32'h0000_0200);

    // Masked pending held, unmask raises request
    do_reset();
    dev_irq[5] = 1'b1;
    ticks(3);
    dev_irq = '0;
    sw_check("mask_hold_sw", 2'b00);
    rd_check("mask_hold_pending", 2'd0, 32'h20);
    wr(2'd1, 32'h20);
    sw_check("unmask_sw", 2'b01);

    // W1C colliding with a new edge on the same channel
    do_reset();
    dev_irq[1] = 1'b1;
    ticks(3);
    rd_check("w1c_first_edge", 2'd0, 32'h02);
    dev_irq = '0;
    ticks(3);
    dev_irq[1] = 1'b1;
    ticks(2);
    wr(2'd0, 32'h02);
    rd_check("w1c_set_wins", 2'd0, 32'h02);
    wr(2'd0, 32'h02);
    rd_check("w1c_clears", 2'd0, 32'h00);
    dev_irq = '0;

    // EOI and accepted ack on the same line in the same cycle
    do_reset();
    wr(2'd1, 32'hFF);
    dev_irq = 8'h06;
    ticks(3);
    dev_irq = '0;
    ack(1'b0);
    rd_check("eoiack_first", 2'd3, 32'h0001_0001);
    wr(2'd3, 32'h1);
    rd_check("eoiack_eoi", 2'd3, 32'h0000_0001);
    int_ack = 1'b1; ack_line = 1'b0;
    wr(2'd3, 32'h1);
    int_ack = 1'b0;
    rd_check("eoiack_ack_wins", 2'd3, 32'h0001_0002);
    rd_check("eoiack_pending", 2'd0, 32'h00);

    // Spurious acks
    do_reset();
    ack(1'b0);
    ack(1'b1);
    rd_check("spurious_isr", 2'd3, 32'h0);

    // Reset mid-service, device held high through reset
    do_reset();
    wr(2'd1, 32'hFF);
    dev_irq = 8'h07;
    ticks(3);
    dev_irq = '0;
    ack(1'b0);
    rd_check("midsvc_pending", 2'd0, 32'h06);
    rd_check("midsvc_isr", 2'd3, 32'h0001_0000);
    dev_irq[7] = 1'b1;
    ticks(3);
    do_reset();
    for (int a = 0; a < 4; a++) rd_check("midsvc_reset_rdata", 2'(a), 32'h0);
    sw_check("midsvc_reset_sw", 2'b00);
    ticks(2);
    rd_check("held_after_2", 2'd0, 32'h00);
    tick();
    rd_check("held_after_3", 2'd0, 32'h80);
    wr(2'd0, 32'h80);
    ticks(3);
    rd_check("held_single_event", 2'd0, 32'h00);
    dev_irq = '0;

    // Randomized traffic against the model
    do_reset();
    wr(2'd1, 32'hFF);
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 2) == 0) dev_irq = dev_irq ^ (N'(1) << $urandom_range(0, N - 1));
      int_ack  = ($urandom_range(0, 4) == 0);
      ack_line = 1'($urandom_range(0, 1));
      bus_we   = ($urandom_range(0, 6) == 0);
      bus_addr = 2'($urandom_range(0, 3));
      bus_wdata = $urandom;
      tick();
    end
    rst = 1'b0; bus_we = 1'b0; int_ack = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
